// File: rtl/trap_ret_if.sv
// Bus between the trap-return sequencer and the core: mret/trap-entry inputs,
// the shared CSR access port and the arbitrated next-PC path.
// master = trap_ret side, slave = core/top-level side.
interface trap_ret_if #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
);
  logic              mret_i;
  logic              trap_in_i;
  logic [XLEN-1:0]   pc_n_i;
  logic [XLEN-1:0]   csr_rdata_i;
  logic [XLEN-1:0]   csr_wdata_o;
  logic              csr_we_o;
  logic [CSR_AW-1:0] csr_addr_o;
  logic [XLEN-1:0]   pc_n_o;
  logic              ret_jump_o;
  logic              ret_busy_o;
  logic              ret_done_o;

  modport master (
    input  mret_i, trap_in_i, pc_n_i, csr_rdata_i,
    output csr_wdata_o, csr_we_o, csr_addr_o, pc_n_o,
           ret_jump_o, ret_busy_o, ret_done_o
  );

  modport slave (
    output mret_i, trap_in_i, pc_n_i, csr_rdata_i,
    input  csr_wdata_o, csr_we_o, csr_addr_o, pc_n_o,
           ret_jump_o, ret_busy_o, ret_done_o
  );
endinterface

// File: rtl/trap_ret.sv
// Trap-return sequencer: on mret restores mstatus.MIE from MPIE, reads mepc, redirects PC.
// Latency: jump strobe 3 cycles after mret is seen in IDLE (longer while trap entry is active).
// Backpressure: waits in WAIT while trap entry owns the CSR port; stalls core via ret_busy_o.
module trap_ret #(
  parameter int              XLEN          = 32,
  parameter int              CSR_AW        = 12,
  parameter logic [11:0]     CSR_MSTATUS   = 12'h300,
  parameter logic [11:0]     CSR_MEPC      = 12'h341,
  parameter logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC
) (
  input  logic        clk,
  input  logic        rst,
  trap_ret_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    RMST = 3'd2,
    RMEP = 3'd3,
    JMPC = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_mepc_q;
  logic [XLEN-1:0] w_mst_restored;

  // MIE <- MPIE, MPIE <- 1, every other mstatus bit kept as read.
  assign w_mst_restored = {bus.csr_rdata_i[XLEN-1:8], 1'b1, bus.csr_rdata_i[6:4],
                           bus.csr_rdata_i[7], bus.csr_rdata_i[2:0]};

  // State register and mepc capture; reset aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mepc_q <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == RMEP) begin
        r_mepc_q <= bus.csr_rdata_i & PC_ALIGN_MASK;
      end
    end
  end

  // Next-state and output decode; the CSR port is driven only while busy.
  always_comb begin
    w_state_nxt     = IDLE;
    bus.csr_we_o    = 1'b0;
    bus.csr_addr_o  = '0;
    bus.csr_wdata_o = '0;
    bus.ret_jump_o  = 1'b0;
    bus.ret_done_o  = 1'b0;
    bus.ret_busy_o  = 1'b0;
    bus.pc_n_o      = bus.pc_n_i;
    case (r_state)
      IDLE: begin
        // Stall fetch combinationally in the detect cycle.
        bus.ret_busy_o = bus.mret_i;
        if (bus.mret_i && bus.trap_in_i) begin
          w_state_nxt = WAIT;       // trap entry wins the CSR port
        end else if (bus.mret_i) begin
          w_state_nxt = RMST;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        bus.ret_busy_o = 1'b1;
        w_state_nxt    = bus.trap_in_i ? WAIT : RMST;
      end
      RMST: begin
        bus.ret_busy_o  = 1'b1;
        bus.csr_addr_o  = CSR_AW'(CSR_MSTATUS);
        bus.csr_we_o    = 1'b1;
        bus.csr_wdata_o = w_mst_restored;
        w_state_nxt     = RMEP;
      end
      RMEP: begin
        bus.ret_busy_o = 1'b1;
        bus.csr_addr_o = CSR_AW'(CSR_MEPC);
        w_state_nxt    = JMPC;
      end
      JMPC: begin
        // mret may still be high here; returning to IDLE without re-sampling it
        // is safe because the decoder drops it once the PC redirects.
        bus.ret_busy_o = 1'b1;
        bus.ret_jump_o = 1'b1;
        bus.ret_done_o = 1'b1;
        bus.pc_n_o     = r_mepc_q;
        w_state_nxt    = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_trap_ret.sv
// Bench for trap_ret: CSR file model plus scoreboard of expected CSR writes and jumps.
// Expected events are queued when an mret is issued and matched by a negedge monitor.
// Direct checks cover reset, stall/WAIT behaviour, reset abort and idle pass-through.
module tb_trap_ret;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  trap_ret_if bus();

  trap_ret dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // CSR file model: preload port plus the DUT's write port.
  logic [31:0] m_mstatus = 32'h0;
  logic [31:0] m_mepc    = 32'h0;
  logic        ld_vld    = 1'b0;
  logic [31:0] ld_ms     = 32'h0;
  logic [31:0] ld_ep     = 32'h0;

  always @(posedge clk) begin
    if (ld_vld) begin
      m_mstatus <= ld_ms;
      m_mepc    <= ld_ep;
    end else if (!rst && bus.csr_we_o && bus.csr_addr_o == 12'h300) begin
      m_mstatus <= bus.csr_wdata_o;
    end
  end

  assign bus.csr_rdata_i = (bus.csr_addr_o == 12'h300) ? m_mstatus :
                           (bus.csr_addr_o == 12'h341) ? m_mepc : 32'h0;

  typedef struct {
    bit          jump;
    int          cyc;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: every CSR write or jump must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.csr_we_o || bus.ret_jump_o)) begin
      if (sb.size() == 0) begin
        check("unexpected_evt", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check("evt_kind", {31'd0, bus.ret_jump_o}, {31'd0, e.jump});
        check("evt_cycle", cyc, e.cyc);
        check("evt_busy", {31'd0, bus.ret_busy_o}, 32'd1);
        if (e.jump) begin
          check("jump_pc", bus.pc_n_o, e.val);
          check("jump_done", {31'd0, bus.ret_done_o}, 32'd1);
          check("jump_we", {31'd0, bus.csr_we_o}, 32'd0);
          check("jump_addr", {20'd0, bus.csr_addr_o}, 32'd0);
        end else begin
          check("wr_addr", {20'd0, bus.csr_addr_o}, 32'h300);
          check("wr_data", bus.csr_wdata_o, e.val);
          check("wr_done", {31'd0, bus.ret_done_o}, 32'd0);
        end
      end
    end
  end

  function automatic logic [31:0] mst_ret(input logic [31:0] ms);
    logic [31:0] r;
    r    = ms;
    r[3] = ms[7];
    r[7] = 1'b1;
    return r;
  endfunction

  task automatic preload(input logic [31:0] ms, input logic [31:0] ep);
    ld_ms  = ms;
    ld_ep  = ep;
    ld_vld = 1'b1;
    @(posedge clk); #1;
    ld_vld = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Issue one mret; trap_cyc > 0 holds trap_in_i high for that many cycles from the detect cycle.
  task automatic do_mret(input logic [31:0] ms, input logic [31:0] ep, input int trap_cyc);
    exp_t w, j;
    preload(ms, ep);
    bus.mret_i    = 1'b1;
    bus.trap_in_i = (trap_cyc > 0);
    w.jump = 1'b0; w.cyc = cyc + trap_cyc + 1; w.val = mst_ret(ms);
    j.jump = 1'b1; j.cyc = cyc + trap_cyc + 3; j.val = ep & 32'hFFFF_FFFC;
    sb.push_back(w);
    sb.push_back(j);
    #1;
    check("busy_detect", {31'd0, bus.ret_busy_o}, 32'd1);
    check("detect_we", {31'd0, bus.csr_we_o}, 32'd0);
    @(posedge clk); #1;
    bus.mret_i = 1'b0;
    for (int i = 1; i < trap_cyc; i++) begin
      check("wait_busy", {31'd0, bus.ret_busy_o}, 32'd1);
      check("wait_we", {31'd0, bus.csr_we_o}, 32'd0);
      @(posedge clk); #1;
    end
    bus.trap_in_i = 1'b0;
    idle_cycles(6);
  endtask

  initial begin
    logic [31:0] sweep [3];
    sweep[0] = 32'h0; sweep[1] = 32'h4; sweep[2] = 32'hFFFF_FFFC;

    bus.mret_i    = 1'b0;
    bus.trap_in_i = 1'b0;
    bus.pc_n_i    = 32'hA5A5_0000;

    // Reset state.
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_pc", bus.pc_n_o, 32'hA5A5_0000);
    check("rst_we", {31'd0, bus.csr_we_o}, 32'd0);
    check("rst_addr", {20'd0, bus.csr_addr_o}, 32'd0);
    check("rst_wdata", bus.csr_wdata_o, 32'd0);
    check("rst_jump", {31'd0, bus.ret_jump_o}, 32'd0);
    check("rst_busy", {31'd0, bus.ret_busy_o}, 32'd0);
    check("rst_done", {31'd0, bus.ret_done_o}, 32'd0);
    check("rst_mepc", dut.r_mepc_q, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(2);

    do_mret(32'h0000_0080, 32'h0000_1234, 0);   // basic return
    do_mret(32'h0000_1808, 32'h0000_4000, 0);   // MPIE = 0
    do_mret(32'h0000_0000, 32'h8000_0037, 0);   // misaligned mepc
    do_mret(32'h0000_1888, 32'h0000_2220, 5);   // trap entry has priority

    // Reset while in RMEP: only the mstatus write may appear, never the jump.
    begin
      exp_t w;
      preload(32'h0000_0080, 32'h2000_0010);
      bus.mret_i = 1'b1;
      w.jump = 1'b0; w.cyc = cyc + 1; w.val = 32'h0000_0088;
      sb.push_back(w);
      @(posedge clk); #1;        // RMST
      bus.mret_i = 1'b0;
      @(posedge clk); #1;        // RMEP
      check("rmep_addr", {20'd0, bus.csr_addr_o}, 32'h341);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", {31'd0, bus.ret_busy_o}, 32'd0);
      check("abort_we", {31'd0, bus.csr_we_o}, 32'd0);
      check("abort_jump", {31'd0, bus.ret_jump_o}, 32'd0);
      check("abort_mepc", dut.r_mepc_q, 32'd0);
      idle_cycles(6);
    end

    // Idle transparency.
    for (int i = 0; i < 3; i++) begin
      bus.pc_n_i = sweep[i];
      #2;
      check("idle_pc", bus.pc_n_o, sweep[i]);
      check("idle_outs", {bus.csr_we_o, bus.ret_jump_o, bus.ret_busy_o, bus.ret_done_o},
            32'd0);
      check("idle_csr", bus.csr_wdata_o | {20'd0, bus.csr_addr_o}, 32'd0);
      @(posedge clk); #1;
    end

    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trap_ret.md
Name: trap_ret

Overview:
- Trap-return sequencer: the exit counterpart of the trap-entry FSM in the core.
- On an `mret` from the decoder it restores `mstatus.MIE` from `MPIE`, fetches the return address from `mepc`, and redirects the PC.
- Sits beside the trap-entry block and shares the single CSR access port with it; the top level ORs both blocks' CSR outputs.
- Owns the port only while busy; drives all-zero otherwise.

Parameters:
- XLEN, 32, data/address width of PC and CSR data.
- CSR_AW, 12, CSR address width.
- CSR_MSTATUS, 12'h300, mstatus address.
- CSR_MEPC, 12'h341, mepc address.
- PC_ALIGN_MASK, 32'hFFFF_FFFC, AND-mask applied to mepc before the jump.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mret_i  in  1  decoded mret, level, valid while the instruction is held in execute
- trap_in_i  in  1  trap-entry block active (its trap_in_o)
- pc_n_i  in  XLEN  next PC from execute (pass-through when not jumping)
- csr_rdata_i  in  XLEN  CSR read data for csr_addr_o (combinational read)
- csr_wdata_o  out  XLEN  CSR write data
- csr_we_o  out  1  CSR write enable
- csr_addr_o  out  CSR_AW  CSR address
- pc_n_o  out  XLEN  arbitrated next PC
- ret_jump_o  out  1  PC redirect strobe
- ret_busy_o  out  1  sequence in progress; top stalls fetch and masks interrupt inputs to trap entry
- ret_done_o  out  1  one-cycle pulse in the jump cycle

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, mepc_q=0.
  - All outputs are 0 except pc_n_o=pc_n_i.
  - Reset mid-sequence aborts at that edge; no further CSR writes are issued.
- Outputs are combinational from state and inputs.
- Defaults in every state: csr_we_o=0, csr_addr_o=0, csr_wdata_o=0, ret_jump_o=0, ret_done_o=0, pc_n_o=pc_n_i.
- IDLE:
  - mret_i & trap_in_i → WAIT (trap entry has priority).
  - mret_i & ~trap_in_i → RMST.
  - Otherwise stay in IDLE.
  - ret_busy_o = mret_i (a combinational stall in the detect cycle).
- WAIT:
  - ret_busy_o=1.
  - Move to RMST on the first cycle with trap_in_i=0.
  - mret_i is not re-sampled.
- RMST:
  - ret_busy_o=1, csr_addr_o=CSR_MSTATUS, csr_we_o=1.
  - csr_wdata_o = {rdata[31:8], 1'b1, rdata[6:4], rdata[7], rdata[2:0]}, i.e. MIE←MPIE, MPIE←1, all other bits unchanged.
  - Next state: RMEP.
- RMEP:
  - ret_busy_o=1, csr_addr_o=CSR_MEPC, csr_we_o=0.
  - mepc_q ← csr_rdata_i & PC_ALIGN_MASK at the edge.
  - Next state: JMPC.
- JMPC:
  - ret_busy_o=1, ret_jump_o=1, ret_done_o=1, pc_n_o=mepc_q, csr_addr_o=0.
  - Next state: IDLE.
- Latency: mret_i with trap_in_i=0 in IDLE gives ret_jump_o exactly 3 cycles later (RMST, RMEP, JMPC = cycles +1, +2, +3).
- From RMST through JMPC:
  - mret_i and trap_in_i are ignored; the sequence always completes.
  - Interrupts enabled by the restored MIE are taken only after ret_busy_o falls (guaranteed by the top-level masking).
- mret_i held high through JMPC does not retrigger: the decoder drops it once the PC redirects. A second mret needs mret_i high while in IDLE.
- Illegal state encodings → IDLE next cycle, outputs at defaults.

Test Plan:
- Basic return: mstatus=0x0000_0080, mepc=0x0000_1234, pulse mret_i → cycle+1 write 0x0000_0088 to 0x300; cycle+3 ret_jump_o=1, pc_n_o=0x0000_1234, ret_done_o=1 for one cycle.
- MPIE=0: mstatus=0x0000_1808 → written value 0x0000_1880 (MIE cleared, MPIE set, MPP bits 0x1800 preserved).
- Misaligned mepc: mepc=0x8000_0037 → pc_n_o=0x8000_0034.
- Trap priority: mret_i and trap_in_i high together, trap_in_i held 5 cycles → state WAIT, no CSR write, ret_busy_o=1; RMST begins the cycle after trap_in_i falls; jump 3 cycles after that.
- Reset mid-sequence: assert rst in RMEP → next cycle IDLE, ret_jump_o never asserts, csr_we_o=0, mepc_q=0.
- Idle transparency: mret_i=0, pc_n_i sweeps 0x0, 0x4, 0xFFFF_FFFC → pc_n_o follows each value; every other output stays 0.
